// File: rtl/dsp_flow_pkg.sv
// Shared definitions for the flow controller: flow-mode encodings, loop state and a clog2 helper.
// The zero-overhead hardware loop is compiled in with the DSP_FLOW_HWLOOP_EN macro.
package dsp_flow_pkg;

    localparam int FLOW_MODE_W = 4;

    typedef enum logic [FLOW_MODE_W-1:0] {
        FM_NONE = 4'd0,
        FM_JMP  = 4'd1,
        FM_BEZ  = 4'd2,
        FM_BNEZ = 4'd3,
        FM_BLTZ = 4'd4,
        FM_BGEZ = 4'd5,
        FM_CALL = 4'd6,
        FM_RET  = 4'd7,
        FM_LOOP = 4'd8
    } flow_mode_e;

    typedef enum logic {
        LOOP_IDLE   = 1'b0,
        LOOP_ACTIVE = 1'b1
    } loop_state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/dsp_ret_stack.sv
// LIFO return-address stack. Only the occupancy counter is reset; entry storage is not.
module dsp_ret_stack
    import dsp_flow_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int STACK_DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push_i,
    input  logic                        pop_i,
    input  logic [ADDR_W-1:0]           data_i,
    output logic                        full_o,
    output logic                        empty_o,
    output logic [ADDR_W-1:0]           top_o,
    output logic [clog2(STACK_DEPTH):0] count_o
);

    localparam int PTR_W = clog2(STACK_DEPTH);
    localparam logic [PTR_W:0]   DEPTH_C = (PTR_W+1)'(STACK_DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    logic [ADDR_W-1:0] mem_q [STACK_DEPTH];
    logic [PTR_W:0]    cnt_q;
    logic [PTR_W:0]    cnt_d;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              push_ok;
    logic              pop_ok;

    assign full_o  = (cnt_q == DEPTH_C);
    assign empty_o = (cnt_q == '0);
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o & ~push_i;

    // When full the low pointer bits wrap to 0, so rd_ptr still lands on the last entry.
    assign wr_ptr  = cnt_q[PTR_W-1:0];
    assign rd_ptr  = wr_ptr - PTR_ONE;
    assign top_o   = mem_q[rd_ptr];
    assign count_o = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (push_ok) begin
            cnt_d = cnt_q + CNT_ONE;
        end else if (pop_ok) begin
            cnt_d = cnt_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr] <= data_i;
        end
    end

endmodule

// File: rtl/dsp_flow_ctrl.sv
// Program-flow controller: branches, call/return stack and sticky stack errors, one-cycle jump latency.
// Define DSP_FLOW_HWLOOP_EN to compile in the zero-overhead hardware loop (LOOP acts as NONE otherwise).
module dsp_flow_ctrl
    import dsp_flow_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int STACK_DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        valid_i,
    input  logic                        flush_i,
    input  logic [FLOW_MODE_W-1:0]      flow_mode,
    input  logic [DATA_W-1:0]           alu_result,
    input  logic [ADDR_W-1:0]           target_addr,
    input  logic [ADDR_W-1:0]           pc_cur,
    input  logic [ADDR_W-1:0]           pc_next,
    input  logic                        err_clr,
    output logic                        jump_flag,
    output logic [ADDR_W-1:0]           jump_addr,
    output logic                        stack_ovf,
    output logic                        stack_unf,
    output logic [clog2(STACK_DEPTH):0] stack_cnt
);

    logic              accept;
    logic              br_take;
    logic [ADDR_W-1:0] br_addr;
    logic              push;
    logic              pop;
    logic              st_full;
    logic              st_empty;
    logic [ADDR_W-1:0] st_top;
    logic              loop_take;
    logic [ADDR_W-1:0] loop_addr;
    logic              jump_flag_q, jump_flag_d;
    logic [ADDR_W-1:0] jump_addr_q, jump_addr_d;
    logic              stack_ovf_q, stack_ovf_d;
    logic              stack_unf_q, stack_unf_d;

    assign accept = valid_i & ~flush_i;

    dsp_ret_stack #(
        .ADDR_W      (ADDR_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_ret_stack (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (pc_next),
        .full_o  (st_full),
        .empty_o (st_empty),
        .top_o   (st_top),
        .count_o (stack_cnt)
    );

    // Explicit jump of the instruction itself; error events override a same-cycle err_clr.
    always_comb begin
        br_take     = 1'b0;
        br_addr     = target_addr;
        push        = 1'b0;
        pop         = 1'b0;
        stack_ovf_d = stack_ovf_q & ~err_clr;
        stack_unf_d = stack_unf_q & ~err_clr;
        if (accept) begin
            case (flow_mode)
                FM_JMP:  br_take = 1'b1;
                FM_BEZ:  br_take = (alu_result == '0);
                FM_BNEZ: br_take = (alu_result != '0);
                FM_BLTZ: br_take = alu_result[DATA_W-1];
                FM_BGEZ: br_take = ~alu_result[DATA_W-1];
                FM_CALL: begin
                    br_take = 1'b1;
                    if (st_full) begin
                        stack_ovf_d = 1'b1;
                    end else begin
                        push = 1'b1;
                    end
                end
                FM_RET: begin
                    if (st_empty) begin
                        stack_unf_d = 1'b1;
                    end else begin
                        pop     = 1'b1;
                        br_take = 1'b1;
                        br_addr = st_top;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef DSP_FLOW_HWLOOP_EN
    localparam logic [DATA_W-1:0] CNT_ONE = DATA_W'(1);

    loop_state_e       loop_state_q, loop_state_d;
    logic [DATA_W-1:0] loop_cnt_q, loop_cnt_d;
    logic [ADDR_W-1:0] loop_start_q, loop_start_d;
    logic [ADDR_W-1:0] loop_end_q, loop_end_d;

    assign loop_addr = loop_start_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            loop_state_q <= LOOP_IDLE;
            loop_cnt_q   <= '0;
            loop_start_q <= '0;
            loop_end_q   <= '0;
        end else begin
            loop_state_q <= loop_state_d;
            loop_cnt_q   <= loop_cnt_d;
            loop_start_q <= loop_start_d;
            loop_end_q   <= loop_end_d;
        end
    end

    // A LOOP instruction always (re)loads; the loop-end jump yields to an explicit taken jump.
    always_comb begin
        loop_state_d = loop_state_q;
        loop_cnt_d   = loop_cnt_q;
        loop_start_d = loop_start_q;
        loop_end_d   = loop_end_q;
        loop_take    = 1'b0;
        if (accept && (flow_mode == FM_LOOP)) begin
            loop_cnt_d   = alu_result;
            loop_start_d = pc_next;
            loop_end_d   = target_addr;
            loop_state_d = (alu_result != '0) ? LOOP_ACTIVE : LOOP_IDLE;
        end else if (accept && (loop_state_q == LOOP_ACTIVE) &&
                     (pc_cur == loop_end_q) && !br_take) begin
            if (loop_cnt_q > CNT_ONE) begin
                loop_take  = 1'b1;
                loop_cnt_d = loop_cnt_q - CNT_ONE;
            end else begin
                loop_state_d = LOOP_IDLE;
            end
        end
    end
`else
    logic unused_pc_cur;

    assign loop_take     = 1'b0;
    assign loop_addr     = '0;
    assign unused_pc_cur = ^pc_cur;
`endif

    always_comb begin
        jump_flag_d = br_take | loop_take;
        jump_addr_d = jump_addr_q;
        if (br_take) begin
            jump_addr_d = br_addr;
        end else if (loop_take) begin
            jump_addr_d = loop_addr;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            jump_flag_q <= 1'b0;
            jump_addr_q <= '0;
            stack_ovf_q <= 1'b0;
            stack_unf_q <= 1'b0;
        end else begin
            jump_flag_q <= jump_flag_d;
            jump_addr_q <= jump_addr_d;
            stack_ovf_q <= stack_ovf_d;
            stack_unf_q <= stack_unf_d;
        end
    end

    assign jump_flag = jump_flag_q;
    assign jump_addr = jump_addr_q;
    assign stack_ovf = stack_ovf_q;
    assign stack_unf = stack_unf_q;

endmodule
